// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI SRAM responder: burst types, response codes
// and the write/read channel FSM states.
package axi_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI subset seen by the SRAM responder: AW/W/B write channels and AR/R read
// channels, 32-bit data, no ID/size/lock/cache/prot signals.
interface axi_sram_slave_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/sram_1r1w_be.sv
// Simple dual-port 32-bit SRAM with per-byte write enables and a registered,
// read-first read port. The read register holds its value while re is low.
module sram_1r1w_be #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset branch so it maps onto block RAM; contents are
  // only meaningful once written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    // NOTE: non-blocking assignments make a same-cycle read of the word being
    // written return the pre-write value (read-first).
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI responder backed by on-chip SRAM: independent write and read channels,
// one outstanding burst each, 32-bit beats, addresses alias modulo the depth.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 14
) (
  input logic             clk,
  input logic             rst,
  axi_sram_slave_if.slave bus
);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  // WRAP is serviced as INCR; FIXED re-uses the start word for every beat.
  function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + idx_t'(1);
  endfunction

  wstate_e     wstate_q, wstate_d;
  idx_t        widx_q, widx_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        werr_q, werr_d;

  rstate_e     rstate_q, rstate_d;
  idx_t        ridx_q, ridx_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [1:0]  rburst_q, rburst_d;
  logic        rerr_q, rerr_d;

  logic [3:0]  sram_we;
  logic        sram_re;
  idx_t        sram_raddr;
  logic [31:0] sram_rdata;
  logic        w_final;
  logic        r_final;

  sram_1r1w_be #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .waddr(widx_q),
    .wdata(bus.wdata),
    .re   (sram_re),
    .raddr(sram_raddr),
    .rdata(sram_rdata)
  );

  assign w_final = (wcnt_q == wlen_q);
  assign r_final = (rcnt_q == rlen_q);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wstate_d    = wstate_q;
    widx_d      = widx_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wburst_d    = wburst_q;
    werr_d      = werr_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = RESP_OKAY;
    sram_we     = '0;

    unique case (wstate_q)
      W_IDLE: begin
        bus.awready = 1'b1;
        if (bus.awvalid) begin
          widx_d   = bus.awaddr[DEPTH_LOG2+1:2];
          wlen_d   = bus.awlen;
          wburst_d = bus.awburst;
          wcnt_d   = '0;
          werr_d   = (bus.awburst == BURST_RSVD);
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          if (wburst_q != BURST_RSVD) begin
            sram_we = bus.wstrb;
          end
          widx_d = next_idx(widx_q, wburst_q);
          wcnt_d = wcnt_q + 4'd1;
          // A misplaced or missing wlast flags the burst but never shortens it.
          if (bus.wlast != w_final) begin
            werr_d = 1'b1;
          end
          if (w_final) begin
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        bus.bresp  = werr_q ? RESP_SLVERR : RESP_OKAY;
        if (bus.bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d    = rstate_q;
    ridx_d      = ridx_q;
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    rburst_d    = rburst_q;
    rerr_d      = rerr_q;
    bus.arready = 1'b0;
    sram_re     = 1'b0;
    sram_raddr  = ridx_q;

    unique case (rstate_q)
      R_IDLE: begin
        bus.arready = 1'b1;
        if (bus.arvalid) begin
          sram_re    = 1'b1;
          sram_raddr = bus.araddr[DEPTH_LOG2+1:2];
          ridx_d     = next_idx(bus.araddr[DEPTH_LOG2+1:2], bus.arburst);
          rlen_d     = bus.arlen;
          rcnt_d     = '0;
          rburst_d   = bus.arburst;
          rerr_d     = (bus.arburst == BURST_RSVD);
          rstate_d   = R_DATA;
        end
      end
      R_DATA: begin
        // ridx_q already points at the following beat, so a handshake can
        // launch its read immediately and keep rvalid high back to back.
        if (bus.rready) begin
          if (r_final) begin
            rstate_d = R_IDLE;
          end else begin
            sram_re = 1'b1;
            ridx_d  = next_idx(ridx_q, rburst_q);
            rcnt_d  = rcnt_q + 8'd1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign bus.rvalid = (rstate_q == R_DATA);
  assign bus.rlast  = bus.rvalid & r_final;
  assign bus.rresp  = (bus.rvalid & rerr_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rdata  = (bus.rvalid & ~rerr_q) ? sram_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wburst_q <= BURST_INCR;
      werr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rburst_q <= BURST_INCR;
      rerr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      widx_q   <= widx_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wburst_q <= wburst_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rburst_q <= rburst_d;
      rerr_q   <= rerr_d;
    end
  end

  // Byte offset and bits above the SRAM index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.awaddr[1:0], bus.araddr[1:0],
                              bus.awaddr[ADDR_W-1:DEPTH_LOG2+2],
                              bus.araddr[ADDR_W-1:DEPTH_LOG2+2]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: single-beat vector table, directed
// burst/backpressure/error/reset sequences, then randomized bursts vs a word-array model.
module tb_axi_sram_slave;
  import axi_slave_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DEPTH_LOG2 = 14;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst;

  axi_sram_slave_if #(.ADDR_W(ADDR_W)) bus ();

  axi_sram_slave #(
    .ADDR_W    (ADDR_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: one 32-bit word per SRAM index, only for written words.
  logic [31:0] model [int];

  logic [31:0] w_data [$];
  logic [3:0]  w_strb [$];
  logic [31:0] r_data [$];
  logic [1:0]  r_resp [$];
  logic        r_last [$];
  logic        r_first_valid;
  logic        r_after_valid;
  logic        r_after_arready;
  int          r_cycles;
  logic [1:0]  last_bresp;

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  wburst;
    logic [31:0] raddr;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", name);
  endtask

  function automatic int beat_idx(input logic [31:0] addr, input int beat, input logic [1:0] burst);
    int base;
    base = int'((addr >> 2) % DEPTH);
    return (burst == 2'b00) ? base : (base + beat) % DEPTH;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    return model.exists(idx) ? model[idx] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int idx;
    logic [31:0] word;
    if (burst == 2'b11) return;
    for (int i = 0; i <= len; i++) begin
      idx  = beat_idx(addr, i, burst);
      word = model_read(idx);
      for (int b = 0; b < 4; b++) begin
        if (w_strb[i][b]) word[8*b +: 8] = w_data[i][8*b +: 8];
      end
      model[idx] = word;
    end
  endtask

  // Write burst from w_data/w_strb; 'bad' flips wlast on that beat, 'hold' delays bready.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int bad, input int hold);
    int n;
    bus.awaddr  = addr;
    bus.awlen   = 4'(len);
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    if (!bus.awready) fail_now("aw_handshake");
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wdata  = w_data[i];
      bus.wstrb  = w_strb[i];
      bus.wlast  = (i == len) ^ (i == bad);
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      if (!bus.wready) fail_now($sformatf("w_beat%0d", i));
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) fail_now("b_valid");
    for (int k = 0; k < hold; k++) begin
      check($sformatf("bhold%0d_bvalid", k), 32'(bus.bvalid), 32'd1);
      check($sformatf("bhold%0d_awready", k), 32'(bus.awready), 32'd0);
      @(negedge clk);
    end
    last_bresp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    if (hold > 0) check("bhold_awready_after", 32'(bus.awready), 32'd1);
    model_write(addr, len, burst);
  endtask

  // Read burst; mode 0 = rready always high, 1 = alternating, 2 = random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input int mode);
    int n, nb;
    logic stalled, rr, hl;
    logic [31:0] hd;
    logic [1:0] hr;
    r_data.delete();
    r_resp.delete();
    r_last.delete();
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (!bus.arready) fail_now("ar_handshake");
    @(negedge clk);
    bus.arvalid   = 1'b0;
    r_first_valid = bus.rvalid;
    nb = 0;
    n = 0;
    stalled = 1'b0;
    hd = '0; hl = 1'b0; hr = '0;
    while (nb <= len && n < 3000) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = 1'(n % 2);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      bus.rready = rr;
      if (bus.rvalid) begin
        if (stalled) begin
          check("stall_rdata", bus.rdata, hd);
          check("stall_rlast", 32'(bus.rlast), 32'(hl));
          check("stall_rresp", 32'(bus.rresp), 32'(hr));
        end
        if (rr) begin
          r_data.push_back(bus.rdata);
          r_resp.push_back(bus.rresp);
          r_last.push_back(bus.rlast);
          nb++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = bus.rdata; hl = bus.rlast; hr = bus.rresp;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.rready = 1'b0;
    r_cycles   = n;
    if (nb <= len) fail_now("r_beats");
    r_after_valid   = bus.rvalid;
    r_after_arready = bus.arready;
  endtask

  task automatic check_read(input string name, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
    logic [31:0] exp;
    if (r_data.size() != len + 1) begin
      fail_now({name, "_count"});
      return;
    end
    for (int i = 0; i <= len; i++) begin
      exp = (burst == 2'b11) ? 32'h0 : model_read(beat_idx(addr, i, burst));
      check($sformatf("%s_d%0d", name, i), r_data[i], exp);
      check($sformatf("%s_resp%0d", name, i), 32'(r_resp[i]), (burst == 2'b11) ? 32'h2 : 32'h0);
      check($sformatf("%s_last%0d", name, i), 32'(r_last[i]), 32'(i == len));
    end
    check({name, "_rvalid_drop"}, 32'(r_after_valid), 32'd0);
    check({name, "_arready_back"}, 32'(r_after_arready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hs, len, start, bad;
    logic [31:0] a;
    logic [1:0] burst;

    vecs[0] = '{32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 2'b01, 32'h0000_0010, 2'b00, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0020, 4'hF, 32'h1122_3344, 2'b01, 32'h0000_0020, 2'b00, 32'h1122_3344};
    vecs[2] = '{32'h0000_0020, 4'h4, 32'h00AA_0000, 2'b01, 32'h0000_0020, 2'b00, 32'h11AA_3344};
    vecs[3] = '{32'hABCD_0044, 4'hF, 32'hCAFE_F00D, 2'b01, 32'h0000_0044, 2'b00, 32'hCAFE_F00D};
    vecs[4] = '{32'h0000_0010, 4'hF, 32'h1234_5678, 2'b11, 32'h0000_0010, 2'b10, 32'hDEAD_BEEF};
    vecs[5] = '{32'h0000_0021, 4'h3, 32'h0000_BBCC, 2'b00, 32'h0000_0020, 2'b00, 32'h11AA_BBCC};
    vecs[6] = '{32'h0000_0044, 4'h0, 32'hFFFF_FFFF, 2'b01, 32'h0001_0044, 2'b00, 32'hCAFE_F00D};

    bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_bresp", 32'(bus.bresp), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rlast", 32'(bus.rlast), 32'd0);
    check("rst_rresp", 32'(bus.rresp), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-beat vectors: full/partial/zero strobes, aliasing, reserved burst.
    for (int i = 0; i < 7; i++) begin
      w_data = '{vecs[i].wdata};
      w_strb = '{vecs[i].wstrb};
      do_write(vecs[i].waddr, 0, vecs[i].wburst, -1, 0);
      check($sformatf("vec%0d_bresp", i), 32'(last_bresp), 32'(vecs[i].exp_bresp));
      do_read(vecs[i].raddr, 0, 2'b01, 0);
      check($sformatf("vec%0d_latency", i), 32'(r_first_valid), 32'd1);
      if (r_data.size() == 1) begin
        check($sformatf("vec%0d_rdata", i), r_data[0], vecs[i].exp_rdata);
        check($sformatf("vec%0d_rlast", i), 32'(r_last[0]), 32'd1);
      end else begin
        fail_now($sformatf("vec%0d_rbeat", i));
      end
    end

    // 4-beat INCR write then back-to-back read.
    w_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    w_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h100, 3, 2'b01, -1, 0);
    check("incr4_bresp", 32'(last_bresp), 32'd0);
    do_read(32'h100, 3, 2'b01, 0);
    check_read("incr4", 32'h100, 3, 2'b01);
    check("incr4_cycles", 32'(r_cycles), 32'd4);
    if (r_data.size() == 4) check("incr4_beat3", r_data[3], 32'd4);

    // FIXED write: only the last beat survives, neighbour untouched.
    w_data = '{32'h5555_AAAA};
    w_strb = '{4'hF};
    do_write(32'h34, 0, 2'b01, -1, 0);
    w_data = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3};
    w_strb = '{4'hF, 4'hF, 4'hF};
    do_write(32'h30, 2, 2'b00, -1, 0);
    do_read(32'h30, 1, 2'b01, 0);
    if (r_data.size() == 2) begin
      check("fixed_word30", r_data[0], 32'hC3C3_C3C3);
      check("fixed_word34", r_data[1], 32'h5555_AAAA);
    end else fail_now("fixed_rbeats");

    // WRAP treated as INCR; index wrap at the top of the array.
    w_data = '{32'h7, 32'h8};
    w_strb = '{4'hF, 4'hF};
    do_write(32'h60, 1, 2'b10, -1, 0);
    do_read(32'h60, 1, 2'b01, 0);
    check_read("wrapburst", 32'h60, 1, 2'b01);
    w_data = '{32'h1357_9BDF, 32'h2468_ACE0};
    do_write(32'h0000_FFFC, 1, 2'b01, -1, 0);
    do_read(32'h0000_0000, 0, 2'b01, 0);
    if (r_data.size() == 1) check("idx_wrap_word0", r_data[0], 32'h2468_ACE0);
    else fail_now("idx_wrap_rbeat");
    do_read(32'h0000_FFFC, 1, 2'b01, 0);
    check_read("idx_wrap", 32'h0000_FFFC, 1, 2'b01);

    // 8-beat read under alternating rready, then FIXED read.
    w_data.delete(); w_strb.delete();
    for (int i = 0; i < 8; i++) begin w_data.push_back($urandom); w_strb.push_back(4'hF); end
    do_write(32'h200, 7, 2'b01, -1, 0);
    do_read(32'h200, 7, 2'b01, 1);
    check_read("stall8", 32'h200, 7, 2'b01);
    do_read(32'h204, 2, 2'b00, 0);
    check_read("fixedrd", 32'h204, 2, 2'b00);

    // B-channel backpressure.
    w_data = '{32'h0BAD_F00D};
    w_strb = '{4'hF};
    do_write(32'h300, 0, 2'b01, -1, 5);
    check("bhold_bresp", 32'(last_bresp), 32'd0);

    // wlast protocol errors: early on beat 2, missing on the final beat.
    w_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    w_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h400, 3, 2'b01, 1, 0);
    check("early_wlast_bresp", 32'(last_bresp), 32'd2);
    do_read(32'h400, 3, 2'b01, 0);
    check_read("early_wlast", 32'h400, 3, 2'b01);
    w_data = '{32'h55, 32'h66};
    w_strb = '{4'hF, 4'hF};
    do_write(32'h410, 1, 2'b01, 1, 0);
    check("missing_wlast_bresp", 32'(last_bresp), 32'd2);

    // Reserved burst: write suppressed, read returns SLVERR with zero data.
    w_data = '{32'h9, 32'h9, 32'h9, 32'h9};
    w_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h100, 3, 2'b11, -1, 0);
    check("rsvd_bresp", 32'(last_bresp), 32'd2);
    do_read(32'h100, 3, 2'b01, 0);
    check_read("rsvd_unchanged", 32'h100, 3, 2'b01);
    do_read(32'h100, 2, 2'b11, 0);
    check_read("rsvd_read", 32'h100, 2, 2'b11);

    // Reset pulsed while beat 3 of an 8-beat read is presented.
    bus.araddr = 32'h200; bus.arlen = 8'd7; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    hs = 0; n = 0;
    while (hs < 2 && n < 50) begin
      if (bus.rvalid) hs++;
      @(negedge clk);
      n++;
    end
    check("midrst_beat3_valid", 32'(bus.rvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rready = 1'b0;
    check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
    check("midrst_rlast", 32'(bus.rlast), 32'd0);
    check("midrst_arready", 32'(bus.arready), 32'd1);
    check("midrst_awready", 32'(bus.awready), 32'd1);
    do_read(32'h200, 7, 2'b01, 0);
    check_read("after_rst", 32'h200, 7, 2'b01);

    // Randomized bursts inside a fully initialised 64-word window at 0x2000.
    for (int k = 0; k < 4; k++) begin
      w_data.delete(); w_strb.delete();
      for (int j = 0; j < 16; j++) begin w_data.push_back($urandom); w_strb.push_back(4'hF); end
      do_write(32'h2000 + 32'(k * 64), 15, 2'b01, -1, 0);
    end
    for (int it = 0; it < 40; it++) begin
      len   = $urandom_range(0, 15);
      start = $urandom_range(0, 63 - len);
      a = (32'($urandom_range(0, 65535)) << 16) | (32'h2000 + 32'(start * 4))
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        burst = 2'($urandom_range(0, 3));
        bad   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
        w_data.delete(); w_strb.delete();
        for (int j = 0; j <= len; j++) begin
          w_data.push_back($urandom);
          w_strb.push_back(4'($urandom_range(0, 15)));
        end
        do_write(a, len, burst, bad, 0);
        check($sformatf("rnd%0d_bresp", it), 32'(last_bresp),
              (burst == 2'b11 || bad >= 0) ? 32'd2 : 32'd0);
      end else begin
        case ($urandom_range(0, 2))
          0:       burst = 2'b00;
          1:       burst = 2'b01;
          default: burst = 2'b11;
        endcase
        do_read(a, len, burst, 2);
        check_read($sformatf("rnd%0d", it), a, len, burst);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI responder that services the `axi_crossbar_2x1` master port (M00) as on-chip memory for simulation and FPGA bring-up of the cached CPU. It accepts INCR/FIXED bursts from the icache/dcache path and returns data from an internal byte-writable synchronous SRAM. Read and write channels are independent, and each handles one outstanding burst.

Parameters:
ADDR_W, 32, width of awaddr/araddr
DEPTH_LOG2, 14, log2 of SRAM depth in 32-bit words (64 KiB default)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
awaddr  in  ADDR_W  write burst start byte address
awlen  in  4  write beats minus 1 (1..16 beats)
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR), 11 reserved
awvalid  in  1  write address valid
awready  out  1  write address accepted
wdata  in  32  write data
wstrb  in  4  byte enables, bit i covers wdata[8i+7:8i]
wlast  in  1  final write beat
wvalid  in  1  write data valid
wready  out  1  write data accepted
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response accepted
araddr  in  ADDR_W  read burst start byte address
arlen  in  8  read beats minus 1 (1..256 beats)
arburst  in  2  same encoding as awburst
arvalid  in  1  read address valid
arready  out  1  read address accepted
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final read beat
rvalid  out  1  read data valid
rready  in  1  read data accepted

Behaviour:
- Reset values: awready=1, arready=1, wready=0, bvalid=0, bresp=00, rvalid=0, rlast=0, rresp=00, rdata=0. SRAM contents are not reset.
- Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias. The index wraps modulo 2^DEPTH_LOG2. addr[1:0] and size are ignored, so all beats are 32-bit.
- Write FSM, W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On the AW handshake, latch index, len and burst; clear the beat counter and err; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb at the current index, then advances the index by 1 (INCR/WRAP) or holds it (FIXED).
  - err is set if wlast=1 on a non-final beat or wlast=0 on the final beat (counter==len). The burst still completes len+1 beats.
  - On the final beat, go to W_RESP.
  - W_RESP: bvalid=1 and bresp={err,0}. Hold until bready, then return to W_IDLE; awready=1 again in the next cycle.
  - awburst=11: set err, suppress all SRAM writes for the burst, still consume the beats.
- Read FSM, R_IDLE → R_DATA:
  - R_IDLE: arready=1. The AR handshake in cycle t issues an SRAM read of the start index; rvalid=1 in cycle t+1.
  - R_DATA: rdata, rlast and rresp stay stable while rvalid & ~rready.
  - On each R handshake of a non-final beat, issue the next read, so rvalid stays high. Sustained throughput is 1 beat/cycle.
  - rlast=1 exactly when the beat counter equals the latched len.
  - The handshake on the last beat drops rvalid and rlast in the next cycle and returns to R_IDLE (arready=1).
  - arburst=11: rresp=10 on every beat, rdata=0.
- Read and write of the same word in the same cycle: the read returns the old data (read-first).
- Reset mid-burst: both FSMs return to idle in the next cycle. The partial burst is dropped and no response is sent. Words already written stay written.

Decomposition:
- Package axi_slave_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/RESP_SLVERR, and the write/read FSM state enums.
- One sub-module, sram_1r1w_be: DEPTH×32 storage, 4-bit byte write enable, synchronous read-first read port, no reset.

Test Plan:
- Single write 0xDEADBEEF to 0x10 (awlen=0, wstrb=1111) → bresp=00; then arlen=0 read of 0x10 → rvalid one cycle after AR, rdata=0xDEADBEEF, rlast=1.
- 4-beat INCR write at 0x100 with data 1,2,3,4, then arlen=3 read with rready held high → 4 consecutive rvalid cycles returning 1,2,3,4, with rlast only on the 4th.
- Write 0x11223344 to 0x20, then wstrb=0100 with wdata=0x00AA0000 → read returns 0x11AA3344. A FIXED 3-beat write to 0x30 → only the last beat's data remains at 0x30 and 0x34 is unchanged.
- Backpressure:
  - rready alternating 0/1 over an 8-beat read → rdata stable during stalls, no beat lost or duplicated.
  - bready held low for 5 cycles → bvalid held and awready=0 throughout.
- awlen=3 with wlast on beat 2 → 4 beats still accepted, bresp=10. awburst=11 → bresp=10 and the SRAM is unchanged.
- rst pulsed during beat 3 of an arlen=7 read → next cycle rvalid=0 and arready=1; a subsequent read of the same address returns correct data.
